// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver with shadow/active digit buffers and registered outputs.
// Define SEG7_BLINK_EN to add the blink_mask port and per-frame blink phase logic.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    hex_mode,
  input  logic                    lz_suppress,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [0:6]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (NUM_DIGITS < 1 || SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_params
    $error("seg7_scan_driver: need NUM_DIGITS>=1, SCAN_DIV>=2, BLINK_FRAMES>=1");
  end

  // Segment patterns, leftmost bit is g, rightmost is a.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0:    p = 7'b0111111;
      4'h1:    p = 7'b0000110;
      4'h2:    p = 7'b1011011;
      4'h3:    p = 7'b1001111;
      4'h4:    p = 7'b1100110;
      4'h5:    p = 7'b1101101;
      4'h6:    p = 7'b1111101;
      4'h7:    p = 7'b0000111;
      4'h8:    p = 7'b1111111;
      4'h9:    p = 7'b1101111;
      4'hA:    p = 7'b1110111;
      4'hB:    p = 7'b1111100;
      4'hC:    p = 7'b0111001;
      4'hD:    p = 7'b1011110;
      4'hE:    p = 7'b1111001;
      default: p = 7'b1110001;
    endcase
    return p;
  endfunction

  logic [CntW-1:0]         cnt_q;
  logic [IdxW-1:0]         idx_q;
  logic [4*NUM_DIGITS-1:0] shadow_data_q, active_data_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, active_dp_q;
  logic                    pending_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    frame_done_q;

  logic cnt_tc, idx_last, commit, blink_off;

  assign cnt_tc   = (cnt_q == CntW'(SCAN_DIV - 1));
  assign idx_last = (idx_q == IdxW'(NUM_DIGITS - 1));
  assign commit   = cnt_tc & idx_last;

  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] upper_zero;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
    assign nib[i] = active_data_q[4*i +: 4];
  end

  // upper_zero[i]: active digits i..N-1 are all zero (leading-zero run reaches digit i).
  always_comb begin
    logic all_zero;
    all_zero   = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero      = all_zero & (nib[i] == 4'd0);
      upper_zero[i] = all_zero;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int unsigned FrW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {PhaseOn, PhaseOff} phase_e;

  phase_e         phase_q;
  logic [FrW-1:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q     <= PhaseOn;
      frame_cnt_q <= '0;
    end else if (commit) begin
      if (frame_cnt_q == FrW'(BLINK_FRAMES - 1)) begin
        frame_cnt_q <= '0;
        phase_q     <= (phase_q == PhaseOn) ? PhaseOff : PhaseOn;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign blink_off = (phase_q == PhaseOff) & blink_mask[idx_q];
`else
  assign blink_off = 1'b0;
`endif

  logic [3:0]            digit;
  logic                  dark;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] an_d;

  always_comb begin
    digit = nib[idx_q];
    dark  = (lz_suppress && (idx_q != '0) && upper_zero[idx_q]) ||
            (!hex_mode && (digit > 4'd9));
    seg_d = decode(digit);
    if (blank_mask[idx_q] || blink_off || dark) begin
      seg_d = '0;
    end
    // Leading-zero and BCD-invalid darkening leave the decimal point alone.
    dp_d  = active_dp_q[idx_q] & ~blank_mask[idx_q] & ~blink_off;
    an_d  = NUM_DIGITS'(1) << idx_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      pending_q     <= 1'b0;
      seg_q         <= '0;
      dp_q          <= 1'b0;
      an_q          <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      if (cnt_tc) begin
        cnt_q <= '0;
        if (idx_last) begin
          idx_q <= '0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      // A load on the commit edge still commits the previous shadow; new data waits a frame.
      if (commit && pending_q) begin
        active_data_q <= shadow_data_q;
        active_dp_q   <= shadow_dp_q;
      end
      if (load) begin
        shadow_data_q <= data_in;
        shadow_dp_q   <= dp_in;
      end
      pending_q <= load | (pending_q & ~commit);

      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= commit;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule
